// File: rtl/univ_rotate_pkg.sv
// Shared encodings for the universal rotate register and its sequencer.
// Control codes match the datapath's 2-bit function select.
package univ_rotate_pkg;

  localparam logic [1:0] CTRL_LOAD = 2'b00;
  localparam logic [1:0] CTRL_ROR  = 2'b01;
  localparam logic [1:0] CTRL_ROL  = 2'b10;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ROT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/univ_rotate_core.sv
// Four-function rotate register: load, rotate left, rotate right, hold.
// Synchronous active-high reset clears the register.
module univ_rotate_core
  import univ_rotate_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic [1:0]    ctrl,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      q <= '0;
    end else begin
      unique case (ctrl)
        CTRL_LOAD: q <= data;
        CTRL_ROL:  q <= {q[DW-2:0], q[DW-1]};
        CTRL_ROR:  q <= {q[0], q[DW-1:1]};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/univ_rotate_seq.sv
// Command sequencer: takes one load/rotate command per handshake and
// steps the rotate register through it, pulsing done when q is final.
module univ_rotate_seq
  import univ_rotate_pkg::*;
#(
  parameter int DW = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_amt,
  input  logic [DW-1:0] cmd_data,
  output logic [DW-1:0] q,
  output logic [1:0]    rot_ctrl,
  output logic          busy,
  output logic          done
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          dir_r;
  logic [DW-1:0] data_r;
  logic          accept;

  assign cmd_ready = (state == IDLE) && !sync_rst;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_r  <= 1'b0;
      data_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= cmd_amt;
        dir_r  <= cmd_dir;
        data_r <= cmd_data;
      end else if (state == ROT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rot_ctrl  = CTRL_HOLD;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          if (cmd_load)
            state_nxt = LOAD;
          else if (cmd_amt != '0)
            state_nxt = ROT;
          else
            state_nxt = DONE;
        end
      end
      LOAD: begin
        rot_ctrl  = CTRL_LOAD;
        state_nxt = (cnt != '0) ? ROT : DONE;
      end
      ROT: begin
        rot_ctrl = dir_r ? CTRL_ROR : CTRL_ROL;
        // cnt is never zero here; <= 1 keeps a stray zero from wrapping
        if (cnt <= CW'(1))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  univ_rotate_core #(
    .DW(DW)
  ) u_core (
    .clk      (clk),
    .sync_rst (sync_rst),
    .ctrl     (rot_ctrl),
    .data     (data_r),
    .q        (q)
  );

endmodule

// File: tb/tb_univ_rotate_seq.sv
// Self-checking bench for univ_rotate_seq: scoreboarded done checks
// plus cycle traces for handshake, back-pressure and abort cases.
module tb_univ_rotate_seq;

  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_load;
  logic          cmd_dir;
  logic [CW-1:0] cmd_amt;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] q;
  logic [1:0]    rot_ctrl;
  logic          busy;
  logic          done;

  univ_rotate_seq #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .q         (q),
    .rot_ctrl  (rot_ctrl),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] eq;
    int            lat;
    int            acc;
  } sb_t;

  typedef struct {
    logic          ld;
    logic          dir;
    logic [CW-1:0] amt;
    logic [DW-1:0] d;
    logic [DW-1:0] eq;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_done = -100;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      last_done = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("done_q", 32'(q), 32'(e.eq));
        check("done_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        check("done_busy", 32'(busy), 32'd1);
        check("done_ready", 32'(cmd_ready), 32'd0);
        check("done_ctrl", 32'(rot_ctrl), 32'b11);
      end
    end
  end

  task automatic send(input logic ld, input logic dir,
                      input logic [CW-1:0] amt, input logic [DW-1:0] d,
                      input logic [DW-1:0] eq);
    int k = 0;
    while (k < 50) begin
      @(negedge clk);
      #1;
      if (cmd_ready) break;
      k++;
    end
    if (k >= 50) begin
      check("send_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_load  = ld;
    cmd_dir   = dir;
    cmd_amt   = amt;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{eq: eq, lat: int'(ld) + int'(amt) + 1, acc: cyc});
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (k < 60) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0 && !busy) return;
      k++;
    end
    check("idle_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] tr3[4];
    int            k;

    tbl[0] = '{ld: 1'b1, dir: 1'b0, amt: 3'd1, d: 4'b0011, eq: 4'b0110};
    tbl[1] = '{ld: 1'b0, dir: 1'b1, amt: 3'd3, d: 4'b1111, eq: 4'b1100};
    tbl[2] = '{ld: 1'b1, dir: 1'b0, amt: 3'd4, d: 4'b1011, eq: 4'b1011};
    tbl[3] = '{ld: 1'b0, dir: 1'b0, amt: 3'd0, d: 4'b0000, eq: 4'b1011};
    tbl[4] = '{ld: 1'b1, dir: 1'b1, amt: 3'd7, d: 4'b1000, eq: 4'b0001};
    tbl[5] = '{ld: 1'b0, dir: 1'b0, amt: 3'd6, d: 4'b1110, eq: 4'b0100};
    tbl[6] = '{ld: 1'b1, dir: 1'b1, amt: 3'd0, d: 4'b0101, eq: 4'b0101};

    sync_rst  = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_dir   = 1'b0;
    cmd_amt   = '0;
    cmd_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ctrl", 32'(rot_ctrl), 32'b11);

    // Load then one left rotate, traced cycle by cycle.
    send(1'b1, 1'b0, 3'd1, 4'b0011, 4'b0110);
    @(negedge clk);
    check("t2_c1_ctrl", 32'(rot_ctrl), 32'b00);
    check("t2_c1_ready", 32'(cmd_ready), 32'd0);
    check("t2_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_c2_ctrl", 32'(rot_ctrl), 32'b10);
    check("t2_c2_q", 32'(q), 32'b0011);
    @(negedge clk);
    check("t2_c3_done", 32'(done), 32'd1);
    @(negedge clk);
    check("t2_c4_ready", 32'(cmd_ready), 32'd1);
    check("t2_c4_busy", 32'(busy), 32'd0);

    // Right rotate by three from 0110.
    tr3 = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};
    send(1'b0, 1'b1, 3'd3, 4'b0000, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t3_q%0d", i), 32'(q), 32'(tr3[i]));
      check($sformatf("t3_busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("t3_ready%0d", i), 32'(cmd_ready), 32'd0);
      if (i < 3)
        check($sformatf("t3_ctrl%0d", i), 32'(rot_ctrl), 32'b01);
    end
    wait_idle();

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].ld, tbl[i].dir, tbl[i].amt, tbl[i].d, tbl[i].eq);
      wait_idle();
    end

    // cmd_valid held high across two commands; data changes mid-flight.
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      #1;
      if (cmd_ready) break;
      k++;
    end
    cmd_load  = 1'b1;
    cmd_dir   = 1'b0;
    cmd_amt   = 3'd2;
    cmd_data  = 4'b0110;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{eq: 4'b1001, lat: 4, acc: cyc});
    cmd_dir  = 1'b1;
    cmd_amt  = 3'd1;
    cmd_data = 4'b0001;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      #1;
      if (cmd_ready) break;
      k++;
    end
    check("t5_ready_after_done", 32'(cyc - last_done), 32'd1);
    check("t5_first_popped", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    sb.push_back('{eq: 4'b1000, lat: 3, acc: cyc});
    cmd_valid = 1'b0;
    wait_idle();

    // Abort an amt=5 rotate in its second ROT cycle.
    send(1'b0, 1'b0, 3'd5, 4'b0000, 4'b0000);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    sync_rst  = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("t6_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    sync_rst  = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t6_q", 32'(q), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ctrl", 32'(rot_ctrl), 32'b11);
    k = last_done;
    repeat (8) @(negedge clk);
    check("t6_no_done", 32'(last_done), 32'(k));
    check("t6_q_hold", 32'(q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_rotate_seq.md
Name: univ_rotate_seq

Overview:
Command sequencer for the universal rotate register datapath. It accepts one command at a time over a valid/ready handshake. Each command specifies an optional parallel load, a rotate direction and a rotate count. The block then drives the register's 2-bit control (load / rotate-left / rotate-right / hold) cycle by cycle, and pulses done when the result in q is final. It sits between a bus-side requester and the rotate datapath, which it instantiates internally.

Parameters:
DW, 4, data/register width in bits (>=2)
CW, 3, width of rotate-count field; max count 2**CW-1

Ports:
clk  input  1  clock, rising edge
sync_rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept command
cmd_load  input  1  1 = parallel-load cmd_data before rotating
cmd_dir  input  1  0 = rotate left (q<<1, msb->lsb), 1 = rotate right (lsb->msb)
cmd_amt  input  CW  number of single-bit rotations
cmd_data  input  DW  load value (used only if cmd_load=1)
q  output  DW  register contents
rot_ctrl  output  2  control currently applied to datapath (00 load, 10 left, 01 right, 11 hold)
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle completion pulse

Behaviour:
- One clock domain, one clock. Reset is synchronous and active-high on sync_rst, sampled at the rising edge of clk.
- Reset values: state=IDLE, q=0, remaining count=0, done=0, busy=0, rot_ctrl=11.
- cmd_ready = (state==IDLE) && !sync_rst. It is combinational and never depends on cmd_valid.
- Handshake: a command is accepted at the edge where cmd_valid && cmd_ready. At that edge cmd_load, cmd_dir, cmd_amt and cmd_data are latched. Later input changes are ignored until the next acceptance.
- FSM states: IDLE, LOAD, ROT, DONE. All outputs except cmd_ready are Moore/registered.
- IDLE: rot_ctrl=11 (hold). On accept, next state is:
  - LOAD if cmd_load=1;
  - else ROT if cmd_amt!=0;
  - else DONE.
  The remaining count is set to cmd_amt.
- LOAD (1 cycle): rot_ctrl=00. At the next edge q<=latched data. Next state is ROT if count!=0, else DONE.
- ROT: rot_ctrl=10 (dir=0) or 01 (dir=1). Each edge q rotates by one bit and count decrements. The block leaves for DONE at the edge where count goes 1->0.
- DONE (1 cycle): rot_ctrl=11, done=1, busy=1, cmd_ready=0. Next state is IDLE.
- Latency: from the accept edge to the done-high cycle = load + amt + 1 cycles. q is final throughout the done cycle and stays held in IDLE.
- Counts >= DW are not reduced modulo DW. The block performs the full amt cycles, so amt=DW returns q to its start value.
- amt=0 with load=0: a no-op command. done rises the cycle after acceptance and q is unchanged.
- cmd_valid held high while busy: no acceptance and no queuing. Earliest next acceptance is the IDLE cycle after done.
- sync_rst mid-command (any state): the command is aborted. q=0, state=IDLE, no done pulse. sync_rst wins over a simultaneous accept.
- Rotate encoding matches the datapath:
  - left: q <= {q[DW-2:0], q[DW-1]}
  - right: q <= {q[0], q[DW-1:1]}

Decomposition:
- Package univ_rotate_pkg holds:
  - control encodings CTRL_LOAD=2'b00, CTRL_ROR=2'b01, CTRL_ROL=2'b10, CTRL_HOLD=2'b11;
  - FSM state encoding (IDLE, LOAD, ROT, DONE).
- One sub-module, univ_rotate_core (params DW). It is the 4-function rotate register with synchronous active-high reset (ports clk, sync_rst, ctrl, data, q). The sequencer drives its ctrl/data; q is passed straight through.
- FSM and count logic stay in univ_rotate_seq.

Test Plan:
1. Apply sync_rst for 2 cycles, then release. Required: q=0000, cmd_ready=1, busy=0, done=0, rot_ctrl=11.
2. Accept load=1, data=0011, dir=0, amt=1. Required: rot_ctrl=00 then 10. q=0011 after 1st edge, 0110 after 2nd. done high in the 3rd cycle after acceptance, then IDLE.
3. From q=0110, accept load=0, dir=1, amt=3. Required: q sequence 0011, 1001, 1100. busy for 4 cycles. done in the 4th. cmd_ready=0 throughout.
4. Accept load=1, data=1011, dir=0, amt=4. Required: q=1011 after load, then 0111, 1110, 1101, 1011. done with q=1011. Then accept load=0, amt=0: done next cycle, q stays 1011.
5. Hold cmd_valid=1 continuously with two different commands. Required: the second command is not accepted until the IDLE cycle after done. Changing cmd_data mid-command has no effect on q.
6. Assert sync_rst in the 2nd ROT cycle of an amt=5 command. Required: next cycle q=0000, state IDLE, cmd_ready=1, and no done pulse at any point.
